// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_t;

  localparam int SEG_W    = 7;
  localparam int NIBBLE_W = 4;

  // One-hot digit drive in the requested polarity; callers truncate to their digit count.
  function automatic logic [31:0] digit_onehot(input int unsigned idx, input logic active_low);
    logic [31:0] onehot;
    onehot = 32'd1 << idx;
    return active_low ? ~onehot : onehot;
  endfunction

endpackage

// File: rtl/seven_segment_display.sv
// Hex nibble to seven-segment decoder; segments[0]=a .. segments[6]=g, active high.
module seven_segment_display
  import seven_seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] value,
  output logic [SEG_W-1:0]    segments
);

  always_comb begin
    segments = '0;
    case (value)
      4'h0: segments = 7'h3F;
      4'h1: segments = 7'h06;
      4'h2: segments = 7'h5B;
      4'h3: segments = 7'h4F;
      4'h4: segments = 7'h66;
      4'h5: segments = 7'h6D;
      4'h6: segments = 7'h7D;
      4'h7: segments = 7'h07;
      4'h8: segments = 7'h7F;
      4'h9: segments = 7'h6F;
      4'hA: segments = 7'h77;
      4'hB: segments = 7'h7C;
      4'hC: segments = 7'h39;
      4'hD: segments = 7'h5E;
      4'hE: segments = 7'h79;
      4'hF: segments = 7'h71;
      default: segments = '0;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Scans NUM_DIGITS digits through one decoder with blanking between dwell slots;
// displayed values only change at frame boundaries.
module seven_segment_scan_controller
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 2,
  parameter int DWELL_CYCLES     = 12000,
  parameter int BLANK_CYCLES     = 200,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] digit_values,
  input  logic [NUM_DIGITS-1:0]          digit_enable,
  input  logic                           load,
  output logic [SEG_W-1:0]               segments,
  output logic [NUM_DIGITS-1:0]          digit_select,
  output logic                           frame_done
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int DATA_W     = NIBBLE_W * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF    = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;

  scan_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_W-1:0]     active;
  logic [DATA_W-1:0]     pending;
  logic                  pending_valid;
  logic [NUM_DIGITS-1:0] drive_on;
  logic [NUM_DIGITS-1:0] drive_next;
  logic [NIBBLE_W-1:0]   cur_value;

  always_comb begin
    drive_on   = NUM_DIGITS'(digit_onehot(32'(idx), 1'(DIGIT_ACTIVE_LOW != 0)));
    drive_next = digit_enable[idx] ? drive_on : ALL_OFF;
    cur_value  = active[NIBBLE_W*int'(idx) +: NIBBLE_W];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_BLANK;
      cnt           <= '0;
      idx           <= '0;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      frame_done    <= 1'b0;
      digit_select  <= ALL_OFF;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        pending       <= digit_values;
        pending_valid <= 1'b1;
      end
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt          <= '0;
            state        <= ST_DRIVE;
            digit_select <= drive_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt == DWELL_LAST) begin
            cnt          <= '0;
            state        <= ST_BLANK;
            digit_select <= ALL_OFF;
            if (idx == IDX_LAST) begin
              // Frame boundary: a same-cycle load bypasses pending; pending_valid clears either way.
              idx           <= '0;
              frame_done    <= 1'b1;
              pending_valid <= 1'b0;
              if (load)
                active <= digit_values;
              else if (pending_valid)
                active <= pending;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt          <= cnt + 1'b1;
            digit_select <= drive_next;
          end
        end
        default: state <= ST_BLANK;
      endcase
    end
  end

  seven_segment_display u_decoder (
    .value    (cur_value),
    .segments (segments)
  );

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller: frame-position reference model, directed then random stimulus.
module tb_seven_segment_scan_controller;

  localparam int ND    = 2;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = ND * SLOT;

  logic            clk = 1'b0;
  logic            reset;
  logic            load;
  logic [4*ND-1:0] digit_values;
  logic [ND-1:0]   digit_enable;
  logic [6:0]      segments;
  logic [ND-1:0]   digit_select;
  logic            frame_done;

  always #5 clk = ~clk;

  seven_segment_scan_controller #(
    .NUM_DIGITS       (ND),
    .DWELL_CYCLES     (DW),
    .BLANK_CYCLES     (BL),
    .DIGIT_ACTIVE_LOW (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .digit_values (digit_values),
    .digit_enable (digit_enable),
    .load         (load),
    .segments     (segments),
    .digit_select (digit_select),
    .frame_done   (frame_done)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: p = edges since reset release (position in the scan timeline).
  int              p = 0;
  logic [4*ND-1:0] m_active  = '0;
  logic [4*ND-1:0] m_pending = '0;
  logic            m_pv      = 1'b0;
  logic [ND-1:0]   en_edge   = '0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (p=%0d, t=%0t)", tag, obs, exp, p, $time);
    end
  endtask

  task automatic tick(input logic rst_n, input logic ld, input logic [4*ND-1:0] dv);
    int            slot;
    int            pos;
    logic [ND-1:0] exp_ds;
    reset        = rst_n;
    load         = ld;
    digit_values = dv;
    @(posedge clk);
    if (!rst_n) begin
      p         = 0;
      m_active  = '0;
      m_pending = '0;
      m_pv      = 1'b0;
    end else begin
      p++;
      en_edge = digit_enable;
      if (p % FRAME == 0) begin
        m_active = ld ? dv : (m_pv ? m_pending : m_active);
        if (ld) m_pending = dv;
        m_pv = 1'b0;
      end else if (ld) begin
        m_pending = dv;
        m_pv      = 1'b1;
      end
    end
    #1;
    slot   = (p % FRAME) / SLOT;
    pos    = (p % FRAME) % SLOT;
    exp_ds = '1;
    if (pos >= BL && en_edge[slot]) exp_ds = ~(ND'(1) << slot);
    check_val("digit_select", 32'(digit_select), 32'(exp_ds));
    check_val("frame_done", 32'(frame_done), 32'(p > 0 && p % FRAME == 0));
    check_val("segments", 32'(segments), 32'(seg_tab[m_active[slot*4 +: 4]]));
    check_val("pending_valid", 32'(dut.pending_valid), 32'(m_pv));
  endtask

  initial begin
    reset        = 1'b0;
    load         = 1'b0;
    digit_values = '0;
    digit_enable = 2'b11;

    // Reset held with load asserted: load must be discarded.
    repeat (3) tick(1'b0, 1'b1, 8'hFF);
    repeat (FRAME) tick(1'b1, 1'b0, 8'h00);

    // Load A3, then two full frames with both digits enabled.
    tick(1'b1, 1'b1, 8'hA3);
    repeat (2 * FRAME) tick(1'b1, 1'b0, 8'h00);

    // Digit 1 disabled.
    digit_enable = 2'b01;
    repeat (FRAME) tick(1'b1, 1'b0, 8'h00);
    digit_enable = 2'b11;

    // Load while digit 1 is driving: no tearing until the boundary.
    while ((p % FRAME) < SLOT + BL) tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'hA7);
    repeat (2 * FRAME) tick(1'b1, 1'b0, 8'h00);

    // Load exactly on the boundary edge: bypasses pending.
    while (((p + 1) % FRAME) != 0) tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h5C);
    repeat (FRAME) tick(1'b1, 1'b0, 8'h00);

    // One-cycle reset during the second dwell cycle of digit 1.
    while ((p % FRAME) != SLOT + BL + 1) tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    repeat (FRAME + 2) tick(1'b1, 1'b0, 8'h00);

    // Random traffic: loads, value changes, enable changes, occasional reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 12 == 0) digit_enable = ND'($urandom);
      tick(1'b1 ^ ($urandom % 150 == 0), ($urandom % 8) == 0, (4*ND)'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
